// File: rtl/ro_pair_measure_ctrl.sv
// Dual ring-oscillator bank measurement controller.
// Counts edges of one bank-1 then one bank-2 oscillator and compares them.
module ro_pair_measure_ctrl #(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       sel_a,
   input  logic [3:0]       sel_b,
   input  logic [15:0]      ro1_out,
   input  logic [15:0]      ro2_out,
   output logic             ro_activate_1,
   output logic             ro_activate_2,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic             sat_a,
   output logic             sat_b,
   output logic             response
);

   localparam int MAXC = (GATE_CYCLES > SETTLE_CYCLES) ?
                         GATE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [TW-1:0]    G_LD = TW'(GATE_CYCLES - 1);
   localparam logic [TW-1:0]    S_LD = TW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE_A,
      GATE_A,
      SETTLE_B,
      GATE_B,
      DONE
   } state_t;

   state_t           state;
   logic [TW-1:0]    timer;
   logic [3:0]       sel_a_q;
   logic [3:0]       sel_b_q;
   logic [CNT_W-1:0] work_a;
   logic [CNT_W-1:0] work_b;
   logic             wsat_a;
   logic             wsat_b;

   logic             samp;
   logic             sync1;
   logic             sync2;
   logic             prev;
   logic             rise;

   logic [CNT_W-1:0] a_nxt;
   logic [CNT_W-1:0] b_nxt;
   logic             sa_nxt;
   logic             sb_nxt;

   // Pick the oscillator of the running bank; 0 keeps the syncs quiet when idle.
   always_comb begin
      samp = 1'b0;
      case (state)
         SETTLE_A, GATE_A: samp = ro1_out[sel_a_q];
         SETTLE_B, GATE_B: samp = ro2_out[sel_b_q];
         default:          samp = 1'b0;
      endcase
   end

   // Two-flop synchronizer plus a delay flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= samp;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

   // Next working counts: saturating increment on a rise inside the gate.
   always_comb begin
      a_nxt  = work_a;
      b_nxt  = work_b;
      sa_nxt = wsat_a;
      sb_nxt = wsat_b;
      if (rise && state == GATE_A) begin
         if (work_a == CMAX) sa_nxt = 1'b1;
         else                a_nxt  = work_a + CNT_W'(1);
      end
      if (rise && state == GATE_B) begin
         if (work_b == CMAX) sb_nxt = 1'b1;
         else                b_nxt  = work_b + CNT_W'(1);
      end
   end

   // Sequencer: timing, bank enables, working counters and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         sel_a_q       <= '0;
         sel_b_q       <= '0;
         work_a        <= '0;
         work_b        <= '0;
         wsat_a        <= 1'b0;
         wsat_b        <= 1'b0;
         ro_activate_1 <= 1'b0;
         ro_activate_2 <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         count_a       <= '0;
         count_b       <= '0;
         sat_a         <= 1'b0;
         sat_b         <= 1'b0;
         response      <= 1'b0;
      end else begin
         done   <= 1'b0;
         work_a <= a_nxt;
         work_b <= b_nxt;
         wsat_a <= sa_nxt;
         wsat_b <= sb_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  sel_a_q       <= sel_a;
                  sel_b_q       <= sel_b;
                  work_a        <= '0;
                  work_b        <= '0;
                  wsat_a        <= 1'b0;
                  wsat_b        <= 1'b0;
                  timer         <= S_LD;
                  busy          <= 1'b1;
                  ro_activate_1 <= 1'b1;
                  state         <= SETTLE_A;
               end
            end
            SETTLE_A: begin
               if (timer == '0) begin
                  timer <= G_LD;
                  state <= GATE_A;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            GATE_A: begin
               if (timer == '0) begin
                  timer         <= S_LD;
                  ro_activate_1 <= 1'b0;
                  ro_activate_2 <= 1'b1;
                  state         <= SETTLE_B;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            SETTLE_B: begin
               if (timer == '0) begin
                  timer <= G_LD;
                  state <= GATE_B;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            GATE_B: begin
               if (timer == '0) begin
                  ro_activate_2 <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  count_a       <= work_a;
                  count_b       <= b_nxt;
                  sat_a         <= wsat_a;
                  sat_b         <= sb_nxt;
                  response      <= (work_a > b_nxt);
                  state         <= DONE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ro_pair_measure_ctrl.sv
// Directed bench for ro_pair_measure_ctrl (G=16, S=4).
// A second instance with CNT_W=2 exercises saturation.
module tb_ro_pair_measure_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  sel_a;
   logic [3:0]  sel_b;
   logic [15:0] ro1_out;
   logic [15:0] ro2_out;

   logic        act1, act2, busy, done, sat_a, sat_b, response;
   logic [15:0] count_a, count_b;

   logic        s_act1, s_act2, s_busy, s_done;
   logic        s_sat_a, s_sat_b, s_resp;
   logic [1:0]  s_cnt_a, s_cnt_b;

   int total = 0;
   int bad   = 0;

   logic [4:0]  ph1 = '0;
   logic [4:0]  ph2 = '0;
   logic [2:0]  d1 = '0;
   logic [2:0]  d2 = '0;
   logic [15:0] mask1 = '0;
   logic [15:0] mask2 = '0;

   ro_pair_measure_ctrl #(
      .GATE_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(16)
   ) u0 (
      .clk(clk), .rst(rst), .start(start),
      .sel_a(sel_a), .sel_b(sel_b),
      .ro1_out(ro1_out), .ro2_out(ro2_out),
      .ro_activate_1(act1), .ro_activate_2(act2),
      .busy(busy), .done(done),
      .count_a(count_a), .count_b(count_b),
      .sat_a(sat_a), .sat_b(sat_b), .response(response)
   );

   ro_pair_measure_ctrl #(
      .GATE_CYCLES(16), .SETTLE_CYCLES(4), .CNT_W(2)
   ) u1 (
      .clk(clk), .rst(rst), .start(start),
      .sel_a(sel_a), .sel_b(sel_b),
      .ro1_out(ro1_out), .ro2_out(ro2_out),
      .ro_activate_1(s_act1), .ro_activate_2(s_act2),
      .busy(s_busy), .done(s_done),
      .count_a(s_cnt_a), .count_b(s_cnt_b),
      .sat_a(s_sat_a), .sat_b(s_sat_b), .response(s_resp)
   );

   always #5 clk = ~clk;

   // Oscillator models: a phase counter that runs only while its bank is enabled.
   always @(posedge clk) begin
      ph1 <= act1 ? ph1 + 5'd1 : 5'd0;
      ph2 <= act2 ? ph2 + 5'd1 : 5'd0;
   end

   assign ro1_out = mask1 & {16{ph1[d1]}};
   assign ro2_out = mask2 & {16{ph2[d2]}};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
         $error("check %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      sel_a = a;
      sel_b = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_act1"}, 32'(act1), 0);
      chk({tag, "_act2"}, 32'(act2), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_cnta"}, 32'(count_a), 0);
      chk({tag, "_cntb"}, 32'(count_b), 0);
      chk({tag, "_sata"}, 32'(sat_a), 0);
      chk({tag, "_satb"}, 32'(sat_b), 0);
      chk({tag, "_resp"}, 32'(response), 0);
   endtask

   initial begin
      int n;
      int nd;

      rst   = 1'b1;
      start = 1'b0;
      sel_a = '0;
      sel_b = '0;

      // Reset state
      repeat (2) tick();
      chk_zero("rst");
      chk("rst_s_cnta", 32'(s_cnt_a), 0);
      chk("rst_s_sata", 32'(s_sat_a), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Basic compare with cycle-exact enable/busy/done spans
      mask1 = 16'h0008; d1 = 3'd1;
      mask2 = 16'h0200; d2 = 3'd2;
      do_start(4'd3, 4'd9);
      for (int c = 1; c <= 41; c++) begin
         chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 40));
         chk($sformatf("act1_c%0d", c), 32'(act1), 32'(c <= 20));
         chk($sformatf("act2_c%0d", c), 32'(act2),
             32'(c >= 21 && c <= 40));
         chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 41));
         chk($sformatf("excl_c%0d", c), 32'(act1 & act2), 0);
         if (c < 41) tick();
      end
      chk("basic_cnta", 32'(count_a), 4);
      chk("basic_cntb", 32'(count_b), 2);
      chk("basic_resp", 32'(response), 1);
      chk("basic_sata", 32'(sat_a), 0);
      chk("basic_satb", 32'(sat_b), 0);
      tick();
      chk("basic_done_pulse", 32'(done), 0);
      chk("basic_hold_a", 32'(count_a), 4);
      chk("basic_hold_b", 32'(count_b), 2);

      // Equal rates
      d2 = 3'd1;
      do_start(4'd3, 4'd9);
      wait_done(n);
      chk("eq_lat", n, 40);
      chk("eq_cnta", 32'(count_a), 4);
      chk("eq_cntb", 32'(count_b), 4);
      chk("eq_resp", 32'(response), 0);
      tick();

      // Selection isolation: every bank-1 bit toggles except bit 5
      mask1 = 16'hFFDF; d1 = 3'd0;
      mask2 = 16'h0000;
      do_start(4'd5, 4'd9);
      wait_done(n);
      chk("iso_lat", n, 40);
      chk("iso_cnta", 32'(count_a), 0);
      chk("iso_cntb", 32'(count_b), 0);
      chk("iso_resp", 32'(response), 0);
      tick();

      // Saturation: toggle every clock, 8 rises in the gate
      mask1 = 16'h0080; d1 = 3'd0;
      mask2 = 16'h0000;
      do_start(4'd7, 4'd2);
      wait_done(n);
      chk("sat_lat", n, 40);
      chk("sat_s_done", 32'(s_done), 1);
      chk("sat_s_cnta", 32'(s_cnt_a), 3);
      chk("sat_s_sata", 32'(s_sat_a), 1);
      chk("sat_s_satb", 32'(s_sat_b), 0);
      chk("sat_s_cntb", 32'(s_cnt_b), 0);
      chk("sat_s_resp", 32'(s_resp), 1);
      chk("sat_cnta", 32'(count_a), 8);
      chk("sat_sata", 32'(sat_a), 0);
      chk("sat_resp", 32'(response), 1);
      tick();

      // Start while busy with different selects is ignored
      mask1 = 16'h0008; d1 = 3'd1;
      mask2 = 16'h0200; d2 = 3'd2;
      do_start(4'd3, 4'd9);
      repeat (9) tick();
      sel_a = 4'd4;
      sel_b = 4'd10;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      nd = 0;
      for (int i = 0; i < 48; i++) begin
         if (done === 1'b1) nd++;
         tick();
      end
      chk("busy_start_ndone", nd, 1);
      chk("busy_start_cnta", 32'(count_a), 4);
      chk("busy_start_cntb", 32'(count_b), 2);
      chk("busy_start_idle", 32'(busy), 0);

      // Reset in the middle of GATE_B
      do_start(4'd3, 4'd9);
      repeat (29) tick();
      chk("mid_act2", 32'(act2), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("midrst");
      nd = 0;
      for (int i = 0; i < 50; i++) begin
         if (done === 1'b1) nd++;
         tick();
      end
      chk("midrst_ndone", nd, 0);
      do_start(4'd3, 4'd9);
      wait_done(n);
      chk("post_rst_lat", n, 40);
      chk("post_rst_cnta", 32'(count_a), 4);
      chk("post_rst_cntb", 32'(count_b), 2);
      chk("post_rst_resp", 32'(response), 1);
      tick();

      // Start held high re-triggers one cycle after DONE
      @(negedge clk);
      sel_a = 4'd3;
      sel_b = 4'd9;
      start = 1'b1;
      tick();
      wait_done(n);
      chk("b2b_lat", n, 40);
      tick();
      chk("b2b_idle_busy", 32'(busy), 0);
      chk("b2b_idle_done", 32'(done), 0);
      tick();
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_act1", 32'(act1), 1);
      wait_done(n);
      chk("b2b2_lat", n, 40);
      chk("b2b2_cnta", 32'(count_a), 4);
      chk("b2b2_cntb", 32'(count_b), 2);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ro_pair_measure_ctrl.md
# ro_pair_measure_ctrl

Measurement controller for the dual 16-way ring-oscillator bank. On `start` it enables bank 1 alone for a settle-plus-gate window and counts rising edges of one selected bank-1 oscillator. It then repeats the window on bank 2 for one selected bank-2 oscillator. It reports both counts and a comparison response bit. It owns `ro_activate_1`/`ro_activate_2`, so only one bank runs at a time, and it sits between the ring-oscillator bank and the tile's control/readout logic.

## Interface
- `GATE_CYCLES`, 1024: clock cycles per counting window (≥1).
- `SETTLE_CYCLES`, 4: cycles after bank enable before counting (≥3; covers synchronizer flush).
- `CNT_W`, 16: width of each edge counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `sel_a` in 4: bank-1 oscillator index; latched when `start` is accepted.
- `sel_b` in 4: bank-2 oscillator index; latched when `start` is accepted.
- `ro1_out` in 16: bank-1 oscillator outputs (asynchronous).
- `ro2_out` in 16: bank-2 oscillator outputs (asynchronous).
- `ro_activate_1` out 1: bank-1 enable (registered).
- `ro_activate_2` out 1: bank-2 enable (registered).
- `busy` out 1: measurement in progress.
- `done` out 1: single-cycle completion pulse.
- `count_a` out CNT_W: bank-1 edge count.
- `count_b` out CNT_W: bank-2 edge count.
- `sat_a` out 1: `count_a` saturated.
- `sat_b` out 1: `count_b` saturated.
- `response` out 1: `count_a > count_b` (unsigned).

## Operation
- FSM states: IDLE → SETTLE_A → GATE_A → SETTLE_B → GATE_B → DONE → IDLE. A single down-counter, sized for max(GATE_CYCLES, SETTLE_CYCLES), times every state.
- IDLE: when `start`=1, latch `sel_a`/`sel_b`, clear the working counters and go to SETTLE_A. `start` is ignored in every other state.
- Sample path: mux (`ro1_out[sel_a]` in the A states, `ro2_out[sel_b]` in the B states, 0 otherwise) → sync1 → sync2 → prev. `rise` = sync2 & ~prev.
- SETTLE_x: bank x is enabled and runs for SETTLE_CYCLES cycles. `rise` is ignored.
- GATE_x: bank x is enabled and runs for GATE_CYCLES cycles. Each cycle with `rise`=1 increments the working counter x. The counter saturates at 2^CNT_W−1 and sets the sticky flag `sat_x`.
- DONE: one cycle. `done`=1; `count_a`, `count_b`, `sat_a`, `sat_b` and `response` are loaded from the working registers.
- Result outputs hold until the next DONE. They are not cleared by a new `start`.
- `ro_activate_1` and `ro_activate_2` are never both 1. Each is 0 in IDLE and DONE.
- Equal counts give `response`=0.
- The mux selects 0 outside the A/B states, so the sync flops settle to 0 in IDLE.

## Timing
- Reset (`rst`=1 at an edge): next cycle the FSM is in IDLE. All outputs are 0: enables, `busy`, `done`, counts, sat flags, `response`. Sync flops and working counters are also 0.
- Reset mid-measurement aborts immediately. No `done` is produced, and enables drop in the cycle after the reset edge.
- Let `start` be accepted at edge T, and let S = SETTLE_CYCLES, G = GATE_CYCLES.
  - `busy` is 1 for cycles T+1 .. T+2(S+G).
  - `ro_activate_1` is 1 for cycles T+1 .. T+S+G.
  - `ro_activate_2` is 1 for cycles T+S+G+1 .. T+2(S+G).
  - `done` is 1 in cycle T+2(S+G)+1, with `busy`=0 in that cycle; results are valid from that cycle.
- Earliest next acceptance is the cycle after DONE.
- Counting latency: an oscillator edge reaches `rise` 2–3 clocks after it occurs. Edges within 2 clocks before a gate ends can be lost; edges from the settle window that arrive late can be counted. Both effects are accepted measurement quantization.
- A back-to-back `start` held high re-triggers from IDLE one cycle after DONE.

## Test plan
Common setup: GATE_CYCLES=16, SETTLE_CYCLES=4, CNT_W=16; ro models run only while their bank enable is high.
- Basic compare: `sel_a`=3 with `ro1_out[3]` at period 4 clk; `sel_b`=9 with `ro2_out[9]` at period 8 clk. Pulse `start`. Required: `count_a`=4, `count_b`=2, `response`=1, `done` exactly at T+41, enables non-overlapping with the spans given in Timing.
- Equal rates: both selected oscillators at period 4. Required: `count_a`=`count_b`=4, `response`=0.
- Selection isolation: all `ro1_out` bits toggle except bit 5 held 0; `sel_a`=5. Required: `count_a`=0.
- Saturation: CNT_W=2, selected bank-1 input toggles every clock. Required: `count_a`=3, `sat_a`=1, `sat_b`=0.
- Start while busy: assert `start` during GATE_A with changed `sel_a`/`sel_b`. Required: ignored, latched selects unchanged, exactly one `done`.
- Reset mid-GATE_B: assert `rst` for 1 cycle. Required: next cycle all outputs 0, no `done`; a subsequent `start` measures normally.
